iot_filter_gen: RTL and testbench

Parametrised IoT data filter: it assembles `DW`-bit data from `IW`-bit input slices and applies one of seven run-time-selectable filter functions. Results are emitted on a single valid-qualified output bus. It replaces the fixed 128-bit/8-bit, compile-time-function filter in the sensor ingest path. It also adds programmable range bounds and group-size/width generics.

---
 rtl/iot_filter_gen.sv | 198 +++++++++++++++++++
 tb/tb_iot_filter_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iot_filter_gen.sv
// Filter that assembles DW-bit data from IW-bit slices and applies a run-time-selected function.
// Define IOTF_AVG_EN to build the group-average function (fn_sel=3) and its accumulator.
module iot_filter_gen #(
    parameter int unsigned DW  = 128,
    parameter int unsigned IW  = 8,
    parameter int unsigned GRP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_en,
    input  logic [IW-1:0] iot_in,
    input  logic [2:0]    fn_sel,
    input  logic [DW-1:0] low,
    input  logic [DW-1:0] high,
    output logic          busy,
    output logic          valid,
    output logic [DW-1:0] iot_out
);

    localparam int unsigned NS = DW / IW;
    localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned LG = (GRP > 1) ? $clog2(GRP) : 1;
`ifdef IOTF_AVG_EN
    localparam int unsigned AW = DW + LG;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_PROC
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   slice_cnt_q, slice_cnt_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [LG-1:0]   grp_cnt_q, grp_cnt_d;
    logic [2:0]      fn_q, fn_d;
    logic [DW-1:0]   run_max_q, run_max_d;
    logic [DW-1:0]   run_min_q, run_min_d;
    logic [DW-1:0]   peak_q, peak_d;
    logic            peak_vld_q, peak_vld_d;
    logic            valid_d;
    logic [DW-1:0]   out_d;
`ifdef IOTF_AVG_EN
    logic [AW-1:0]   acc_q, acc_d, acc_sum;
`endif

    logic            accept;
    logic            last_slice;
    logic            grp_first;
    logic            grp_end;
    logic [DW-1:0]   grp_max;
    logic [DW-1:0]   grp_min;

    assign accept     = in_en & ~busy;
    assign last_slice = (slice_cnt_q == CW'(NS - 1));
    assign grp_first  = (grp_cnt_q == '0);
    assign grp_end    = (grp_cnt_q == LG'(GRP - 1));
    // The first datum of a group seeds the running extremes.
    assign grp_max    = (grp_first || (shift_q > run_max_q)) ? shift_q : run_max_q;
    assign grp_min    = (grp_first || (shift_q < run_min_q)) ? shift_q : run_min_q;
`ifdef IOTF_AVG_EN
    assign acc_sum    = acc_q + AW'(shift_q);
`endif

    // Slice capture, function latching and per-datum processing in PROC.
    always_comb begin
        slice_cnt_d = slice_cnt_q;
        shift_d     = shift_q;
        grp_cnt_d   = grp_cnt_q;
        fn_d        = fn_q;
        run_max_d   = run_max_q;
        run_min_d   = run_min_q;
        peak_d      = peak_q;
        peak_vld_d  = peak_vld_q;
        valid_d     = 1'b0;
        out_d       = iot_out;
`ifdef IOTF_AVG_EN
        acc_d       = acc_q;
`endif

        if (accept) begin
            shift_d     = (shift_q << IW) | DW'(iot_in);
            slice_cnt_d = last_slice ? '0 : slice_cnt_q + CW'(1);
            if ((slice_cnt_q == '0) && grp_first) begin
                fn_d = fn_sel;
                if (fn_sel != fn_q) begin
                    peak_vld_d = 1'b0;
`ifdef IOTF_AVG_EN
                    acc_d      = '0;
`endif
                end
            end
        end

        if (state_q == S_PROC) begin
            grp_cnt_d = grp_cnt_q + LG'(1);
            run_max_d = grp_max;
            run_min_d = grp_min;
            case (fn_q)
                3'd1: if (grp_end) begin
                    valid_d = 1'b1;
                    out_d   = grp_max;
                end
                3'd2: if (grp_end) begin
                    valid_d = 1'b1;
                    out_d   = grp_min;
                end
`ifdef IOTF_AVG_EN
                3'd3: begin
                    if (grp_end) begin
                        valid_d = 1'b1;
                        out_d   = DW'(acc_sum >> LG);
                        acc_d   = '0;
                    end else begin
                        acc_d   = acc_sum;
                    end
                end
`endif
                3'd4: if ((shift_q > low) && (shift_q < high)) begin
                    valid_d = 1'b1;
                    out_d   = shift_q;
                end
                3'd5: if ((shift_q < low) || (shift_q > high)) begin
                    valid_d = 1'b1;
                    out_d   = shift_q;
                end
                3'd6: if (grp_end && (!peak_vld_q || (grp_max > peak_q))) begin
                    valid_d    = 1'b1;
                    out_d      = grp_max;
                    peak_d     = grp_max;
                    peak_vld_d = 1'b1;
                end
                3'd7: if (grp_end && (!peak_vld_q || (grp_min < peak_q))) begin
                    valid_d    = 1'b1;
                    out_d      = grp_min;
                    peak_d     = grp_min;
                    peak_vld_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FSM, busy flag and all state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            valid       <= 1'b0;
            iot_out     <= '0;
            slice_cnt_q <= '0;
            shift_q     <= '0;
            grp_cnt_q   <= '0;
            fn_q        <= '0;
            run_max_q   <= '0;
            run_min_q   <= '0;
            peak_q      <= '0;
            peak_vld_q  <= 1'b0;
`ifdef IOTF_AVG_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    state_q <= last_slice ? S_PROC : S_RECV;
                    busy    <= last_slice;
                end
                S_RECV: if (accept && last_slice) begin
                    state_q <= S_PROC;
                    busy    <= 1'b1;
                end
                S_PROC: begin
                    state_q <= S_RECV;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
            valid       <= valid_d;
            iot_out     <= out_d;
            slice_cnt_q <= slice_cnt_d;
            shift_q     <= shift_d;
            grp_cnt_q   <= grp_cnt_d;
            fn_q        <= fn_d;
            run_max_q   <= run_max_d;
            run_min_q   <= run_min_d;
            peak_q      <= peak_d;
            peak_vld_q  <= peak_vld_d;
`ifdef IOTF_AVG_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_iot_filter_gen.sv
// Directed-vector bench for iot_filter_gen at the default 128/8/8 configuration.
module tb_iot_filter_gen;

    localparam int unsigned DW = 128;
    localparam int unsigned IW = 8;
    localparam int unsigned NS = DW / IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_en;
    logic [IW-1:0] iot_in;
    logic [2:0]    fn_sel;
    logic [DW-1:0] low;
    logic [DW-1:0] high;
    logic          busy;
    logic          valid;
    logic [DW-1:0] iot_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;

    iot_filter_gen #(.DW(DW), .IW(IW), .GRP(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .iot_in  (iot_in),
        .fn_sel  (fn_sel),
        .low     (low),
        .high    (high),
        .busy    (busy),
        .valid   (valid),
        .iot_out (iot_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) n_valid++;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Enter and leave reset; returns positioned at a falling edge.
    task automatic do_reset();
        in_en = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        @(negedge clk);
    endtask

    // Sends one datum MS slice first; returns at the falling edge where the PROC result is visible.
    task automatic send_datum(input logic [DW-1:0] d, input bit drop_probe);
        logic [DW-1:0] tmp;
        tmp = d;
        for (int i = 0; i < NS; i++) begin
            in_en  = 1'b1;
            iot_in = tmp[DW-1 -: IW];
            tmp    = tmp << IW;
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy_in_proc", {127'd0, busy}, 128'd1);
        in_en  = drop_probe;
        iot_in = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_en  = 1'b0;
    endtask

    logic [DW-1:0] d;
    int            base;
    logic [7:0]    fa [8];
    logic [7:0]    fb [8];

    initial begin
        rst    = 1'b0;
        in_en  = 1'b0;
        iot_in = '0;
        fn_sel = 3'd0;
        low    = '0;
        high   = '0;
        @(negedge clk);
        chk("rst_busy",  {127'd0, busy},  128'd0);
        chk("rst_valid", {127'd0, valid}, 128'd0);
        chk("rst_out",   iot_out,         128'd0);
        rst = 1'b1;
        @(negedge clk);

        // Function 1: running max, one result at group end
        fn_sel = 3'd1;
        base = n_valid;
        for (int i = 0; i < 8; i++) begin
            d = (i == 5) ? 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF : {8'(8'h10 + i), 120'd0};
            send_datum(d, 1'b0);
            if (i < 7) chk("max_quiet", {127'd0, valid}, 128'd0);
        end
        chk("max_valid", {127'd0, valid}, 128'd1);
        chk("max_out", iot_out, 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("max_valid_cnt", 128'(n_valid - base), 128'd1);
        chk("max_pulse_1cyc", {127'd0, valid}, 128'd0);

        // Function 3: average (only when compiled in)
        do_reset();
        fn_sel = 3'd3;
        base = n_valid;
        for (int i = 0; i < 8; i++) send_datum((i == 2) ? 128'h18 : 128'h10, 1'b0);
`ifdef IOTF_AVG_EN
        chk("avg_valid", {127'd0, valid}, 128'd1);
        chk("avg_out", iot_out, 128'h11);
        @(negedge clk);
        chk("avg_valid_cnt", 128'(n_valid - base), 128'd1);
`else
        @(negedge clk);
        chk("avg_off_valid_cnt", 128'(n_valid - base), 128'd0);
        chk("avg_off_out", iot_out, 128'd0);
`endif

        // Function 4: strict range extract, with a slice offered during busy
        do_reset();
        fn_sel = 3'd4;
        low    = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        high   = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        send_datum(128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("ext_low_bound", {127'd0, valid}, 128'd0);
        send_datum(128'h7000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        chk("ext_inside_valid", {127'd0, valid}, 128'd1);
        chk("ext_inside_out", iot_out, 128'h7000_0000_0000_0000_0000_0000_0000_0000);
        send_datum(128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("ext_high_bound", {127'd0, valid}, 128'd0);
        send_datum(128'hB000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        chk("ext_above", {127'd0, valid}, 128'd0);
        chk("ext_out_hold", iot_out, 128'h7000_0000_0000_0000_0000_0000_0000_0000);

        // Reset mid-datum, then a fresh datum through an open extract window
        low  = '0;
        high = '1;
        for (int i = 0; i < 7; i++) begin
            in_en  = 1'b1;
            iot_in = 8'hEE;
            @(posedge clk);
            @(negedge clk);
        end
        in_en = 1'b0;
        rst   = 1'b0;
        #1;
        chk("midrst_busy",  {127'd0, busy},  128'd0);
        chk("midrst_valid", {127'd0, valid}, 128'd0);
        chk("midrst_out",   iot_out,         128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_datum(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        chk("fresh_valid", {127'd0, valid}, 128'd1);
        chk("fresh_out", iot_out, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        // Function 6: peak-max across three groups
        do_reset();
        fn_sel = 3'd6;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 8; i++) begin
                d = {8'(8'h10 + i), 120'd0};
                if (i == 3) d = (g == 0) ? {8'h80, 120'd0} : (g == 1) ? {8'h70, 120'd0} : {8'h90, 120'd0};
                send_datum(d, 1'b0);
            end
            if (g == 0) begin
                chk("peak_g0_valid", {127'd0, valid}, 128'd1);
                chk("peak_g0_out", iot_out, {8'h80, 120'd0});
            end else if (g == 1) begin
                chk("peak_g1_silent", {127'd0, valid}, 128'd0);
                chk("peak_g1_hold", iot_out, {8'h80, 120'd0});
            end else begin
                chk("peak_g2_valid", {127'd0, valid}, 128'd1);
                chk("peak_g2_out", iot_out, {8'h90, 120'd0});
            end
        end

        // fn_sel 1 -> 2 mid-group takes effect only at the next group
        do_reset();
        fa = '{8'h30, 8'h50, 8'h20, 8'h40, 8'h35, 8'h45, 8'h25, 8'h12};
        fb = '{8'h60, 8'h40, 8'h70, 8'h15, 8'h90, 8'h22, 8'h33, 8'h44};
        fn_sel = 3'd1;
        for (int i = 0; i < 8; i++) begin
            send_datum({fa[i], 120'd0}, 1'b0);
            if (i == 3) fn_sel = 3'd2;
        end
        chk("chg_max_valid", {127'd0, valid}, 128'd1);
        chk("chg_max_out", iot_out, {8'h50, 120'd0});
        for (int i = 0; i < 8; i++) send_datum({fb[i], 120'd0}, 1'b0);
        chk("chg_min_valid", {127'd0, valid}, 128'd1);
        chk("chg_min_out", iot_out, {8'h15, 120'd0});

        // Reserved function: data consumed, never a result
        do_reset();
        fn_sel = 3'd0;
        base = n_valid;
        for (int i = 0; i < 8; i++) send_datum({8'(8'h20 + i), 120'd0}, 1'b0);
        @(negedge clk);
        chk("fn0_valid_cnt", 128'(n_valid - base), 128'd0);
        chk("fn0_out", iot_out, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
